// File: rtl/alu_pkg.sv
// Package: alu_pkg
// Purpose: shared encodings for the control unit, the ALU control block and
//          the ALU datapath: control-unit opcodes, R-type funct codes, ALU
//          commands, the control FSM state type and a helper that tells
//          which commands occupy the ALU for more than one cycle.
// Ports:   none (package).
package alu_pkg;

   localparam int OP_W    = 4;
   localparam int FUNCT_W = 6;
   localparam int CMD_W   = 4;

   // Control-unit ALU opcodes
   localparam logic [OP_W-1:0] OP_ADD   = 4'd0;
   localparam logic [OP_W-1:0] OP_SUB   = 4'd1;
   localparam logic [OP_W-1:0] OP_MUL   = 4'd2;
   localparam logic [OP_W-1:0] OP_AND   = 4'd3;
   localparam logic [OP_W-1:0] OP_OR    = 4'd4;
   localparam logic [OP_W-1:0] OP_RTYPE = 4'd5;

   // R-type funct field codes
   localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'h20;
   localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'h22;
   localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'h24;
   localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'h25;
   localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'h2A;
   localparam logic [FUNCT_W-1:0] FUNCT_MUL = 6'h18;
   localparam logic [FUNCT_W-1:0] FUNCT_DIV = 6'h1A;

   // ALU commands
   localparam logic [CMD_W-1:0] CMD_ADD = 4'd0;
   localparam logic [CMD_W-1:0] CMD_SUB = 4'd1;
   localparam logic [CMD_W-1:0] CMD_MUL = 4'd2;
   localparam logic [CMD_W-1:0] CMD_AND = 4'd3;
   localparam logic [CMD_W-1:0] CMD_OR  = 4'd4;
   localparam logic [CMD_W-1:0] CMD_SLT = 4'd5;
   localparam logic [CMD_W-1:0] CMD_DIV = 4'd6;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   function automatic logic is_multicycle(input logic [CMD_W-1:0] cmd);
      return (cmd == CMD_MUL) || (cmd == CMD_DIV);
   endfunction

endpackage

// File: rtl/alu_ctrl_mc_if.sv
// Interface: alu_ctrl_mc_if
// Purpose: bundles the request/response signals between the pipeline
//          control (master) and the ALU control block (slave).
// Signals:
//   in_valid, op_in, funct_in, flush   master -> slave
//   in_ready, cmd_out, cmd_valid,
//   alu_busy, done, illegal_op         slave  -> master
interface alu_ctrl_mc_if #(
   parameter int OP_W    = 4,
   parameter int FUNCT_W = 6,
   parameter int CMD_W   = 4
);
   logic               in_valid;
   logic               in_ready;
   logic [OP_W-1:0]    op_in;
   logic [FUNCT_W-1:0] funct_in;
   logic               flush;
   logic [CMD_W-1:0]   cmd_out;
   logic               cmd_valid;
   logic               alu_busy;
   logic               done;
   logic               illegal_op;

   modport master (
      output in_valid, op_in, funct_in, flush,
      input  in_ready, cmd_out, cmd_valid, alu_busy, done, illegal_op
   );

   modport slave (
      input  in_valid, op_in, funct_in, flush,
      output in_ready, cmd_out, cmd_valid, alu_busy, done, illegal_op
   );
endinterface

// File: rtl/alu_funct_decode.sv
// Module: alu_funct_decode
// Purpose: purely combinational decode of control-unit opcode and R-type
//          funct field into an ALU command.
// Ports:
//   op_in      in   OP_W     control-unit ALU opcode
//   funct_in   in   FUNCT_W  instruction funct field (R-type only)
//   cmd        out  CMD_W    decoded ALU command (0 when illegal)
//   legal      out  1        opcode/funct combination is decodable
//   multicycle out  1        legal command that occupies the ALU > 1 cycle
module alu_funct_decode
   import alu_pkg::*;
#(
   parameter int OP_W    = 4,
   parameter int FUNCT_W = 6,
   parameter int CMD_W   = 4
) (
   input  logic [OP_W-1:0]    op_in,
   input  logic [FUNCT_W-1:0] funct_in,
   output logic [CMD_W-1:0]   cmd,
   output logic               legal,
   output logic               multicycle
);

   always_comb begin
      cmd   = '0;
      legal = 1'b1;
      if (op_in == OP_W'(OP_RTYPE)) begin
         case (funct_in)
            FUNCT_W'(FUNCT_ADD): cmd = CMD_W'(CMD_ADD);
            FUNCT_W'(FUNCT_SUB): cmd = CMD_W'(CMD_SUB);
            FUNCT_W'(FUNCT_AND): cmd = CMD_W'(CMD_AND);
            FUNCT_W'(FUNCT_OR):  cmd = CMD_W'(CMD_OR);
            FUNCT_W'(FUNCT_SLT): cmd = CMD_W'(CMD_SLT);
            FUNCT_W'(FUNCT_MUL): cmd = CMD_W'(CMD_MUL);
            FUNCT_W'(FUNCT_DIV): cmd = CMD_W'(CMD_DIV);
            default:             legal = 1'b0;
         endcase
      end else if (op_in <= OP_W'(OP_OR)) begin
         // Direct opcodes share their numeric value with the command
         cmd = CMD_W'(op_in);
      end else begin
         legal = 1'b0;
      end
   end

   assign multicycle = legal && is_multicycle(cmd);

endmodule

// File: rtl/alu_ctrl_mc.sv
// Module: alu_ctrl_mc
// Purpose: ALU control unit. Decodes opcode/funct into a registered ALU
//          command (latency 1) and sequences multi-cycle MUL/DIV with a
//          busy/done handshake toward the pipeline.
// Ports:
//   clk    in  1  clock, rising edge
//   rst_n  in  1  asynchronous active-low reset
//   bus    slave modport of alu_ctrl_mc_if (in_valid/in_ready/op_in/
//          funct_in/flush in; cmd_out/cmd_valid/alu_busy/done/illegal_op out)
module alu_ctrl_mc
   import alu_pkg::*;
#(
   parameter int OP_W    = 4,
   parameter int FUNCT_W = 6,
   parameter int CMD_W   = 4,
   parameter int MUL_LAT = 4,
   parameter int DIV_LAT = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   alu_ctrl_mc_if.slave  bus
);

   localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT) + 1;

   state_t             state_reg, state_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic [CMD_W-1:0]   cmd_reg, cmd_next;
   logic               cmd_valid_reg, cmd_valid_next;
   logic               illegal_reg, illegal_next;
   logic               done_comb;
   logic               in_ready;
   logic               accept;

   logic [CMD_W-1:0]   dec_cmd;
   logic               dec_legal;
   logic               dec_multi;

   alu_funct_decode #(
      .OP_W    (OP_W),
      .FUNCT_W (FUNCT_W),
      .CMD_W   (CMD_W)
   ) u_decode (
      .op_in      (bus.op_in),
      .funct_in   (bus.funct_in),
      .cmd        (dec_cmd),
      .legal      (dec_legal),
      .multicycle (dec_multi)
   );

   // flush has priority over a new request
   assign in_ready = (state_reg == ST_IDLE) && !bus.flush;
   assign accept   = bus.in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         cnt_reg       <= '0;
         cmd_reg       <= CMD_W'(CMD_ADD);
         cmd_valid_reg <= 1'b0;
         illegal_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         cmd_reg       <= cmd_next;
         cmd_valid_reg <= cmd_valid_next;
         illegal_reg   <= illegal_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      cmd_next       = cmd_reg;
      cmd_valid_next = 1'b0;
      illegal_next   = 1'b0;
      done_comb      = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (accept) begin
               if (!dec_legal) begin
                  // Undecodable: report only, command register untouched
                  illegal_next = 1'b1;
               end else begin
                  cmd_next       = dec_cmd;
                  cmd_valid_next = 1'b1;
                  if (dec_multi) begin
                     // Count down to 0 so busy lasts exactly LAT cycles
                     cnt_next   = (dec_cmd == CMD_W'(CMD_DIV)) ?
                                  CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
                     state_next = ST_BUSY;
                  end
               end
            end
         end
         ST_BUSY: begin
            if (bus.flush) begin
               // Abort: no completion is reported for a flushed op
               state_next = ST_IDLE;
               cnt_next   = '0;
            end else if (cnt_reg == '0) begin
               done_comb  = 1'b1;
               state_next = ST_IDLE;
            end else begin
               cnt_next = cnt_reg - 1'b1;
            end
         end
         default: begin
            state_next = ST_IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   assign bus.in_ready   = in_ready;
   assign bus.cmd_out    = cmd_reg;
   assign bus.cmd_valid  = cmd_valid_reg;
   assign bus.alu_busy   = (state_reg == ST_BUSY);
   assign bus.done       = done_comb;
   assign bus.illegal_op = illegal_reg;

endmodule

// File: tb/tb_alu_ctrl_mc.sv
// Testbench for alu_ctrl_mc. Two instances: dut_a with default latencies,
// dut_b with MUL_LAT=1. Expected output events are queued as stimulus is
// issued; a negedge monitor pops and compares whenever a DUT pulses
// cmd_valid, done or illegal_op.
module tb_alu_ctrl_mc;
   import alu_pkg::*;

   localparam int K_CMD  = 0;
   localparam int K_DONE = 1;
   localparam int K_ILL  = 2;

   typedef struct {
      int         kind;
      logic [3:0] cmd;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   exp_t q_a[$];
   exp_t q_b[$];

   always #5 clk = ~clk;

   alu_ctrl_mc_if bus_a ();
   alu_ctrl_mc_if bus_b ();

   alu_ctrl_mc #(.MUL_LAT(4), .DIV_LAT(8)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a.slave)
   );

   alu_ctrl_mc #(.MUL_LAT(1), .DIV_LAT(8)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b.slave)
   );

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   task automatic push(input int d, input int kind, input logic [3:0] cmd);
      exp_t e;
      e.kind = kind;
      e.cmd  = cmd;
      if (d == 0) q_a.push_back(e);
      else        q_b.push_back(e);
   endtask

   task automatic pop_check(input int d, input int kind, input logic [3:0] co);
      exp_t e;
      checks++;
      if ((d == 0 && q_a.size() == 0) || (d == 1 && q_b.size() == 0)) begin
         errors++;
         $display("FAIL dut%0d unexpected event kind=%0d cmd_out=%0d", d, kind, co);
      end else begin
         if (d == 0) e = q_a.pop_front();
         else        e = q_b.pop_front();
         if (e.kind != kind || (kind != K_DONE && co != e.cmd)) begin
            errors++;
            $display("FAIL dut%0d event: got kind=%0d cmd_out=%0d expected kind=%0d cmd=%0d",
                     d, kind, co, e.kind, e.cmd);
         end else begin
            $display("dut%0d event kind=%0d cmd_out=%0d ok", d, kind, co);
         end
      end
   endtask

   task automatic mon(input int d, input logic cv, input logic dn,
                      input logic il, input logic [3:0] co);
      if (cv) pop_check(d, K_CMD, co);
      if (dn) pop_check(d, K_DONE, co);
      if (il) pop_check(d, K_ILL, co);
   endtask

   // Monitor
   always @(negedge clk) begin
      if (rst_n) begin
         mon(0, bus_a.cmd_valid, bus_a.done, bus_a.illegal_op, bus_a.cmd_out);
         mon(1, bus_b.cmd_valid, bus_b.done, bus_b.illegal_op, bus_b.cmd_out);
      end
   end

   // Present one request and hold it for exactly one clock edge
   task automatic issue(input int d, input logic [3:0] op, input logic [5:0] funct);
      int n = 0;
      while (((d == 0) ? bus_a.in_ready : bus_b.in_ready) !== 1'b1 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 100) chk("in_ready_timeout", 0, 1);
      if (d == 0) begin
         bus_a.in_valid = 1'b1; bus_a.op_in = op; bus_a.funct_in = funct;
      end else begin
         bus_b.in_valid = 1'b1; bus_b.op_in = op; bus_b.funct_in = funct;
      end
      @(posedge clk);
      #1;
      bus_a.in_valid = 1'b0;
      bus_b.in_valid = 1'b0;
   endtask

   initial begin
      bus_a.in_valid = 1'b0; bus_a.op_in = '0; bus_a.funct_in = '0; bus_a.flush = 1'b0;
      bus_b.in_valid = 1'b0; bus_b.op_in = '0; bus_b.funct_in = '0; bus_b.flush = 1'b0;

      // Reset state
      #12;
      chk("rst_cmd_out", int'(bus_a.cmd_out), 0);
      chk("rst_cmd_valid", int'(bus_a.cmd_valid), 0);
      chk("rst_alu_busy", int'(bus_a.alu_busy), 0);
      chk("rst_done", int'(bus_a.done), 0);
      chk("rst_illegal", int'(bus_a.illegal_op), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: asynchronous reset in the third DIV busy cycle (cnt=5)
      push(0, K_CMD, CMD_DIV);
      issue(0, OP_RTYPE, FUNCT_DIV);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("t1_busy_before_rst", int'(bus_a.alu_busy), 1);
      rst_n = 1'b0;
      #1;
      chk("t1_cmd_out", int'(bus_a.cmd_out), 0);
      chk("t1_cmd_valid", int'(bus_a.cmd_valid), 0);
      chk("t1_alu_busy", int'(bus_a.alu_busy), 0);
      chk("t1_done", int'(bus_a.done), 0);
      chk("t1_illegal", int'(bus_a.illegal_op), 0);
      chk("t1_in_ready", int'(bus_a.in_ready), 1);
      @(negedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 2: single-cycle op, then back-to-back SUB, OR
      push(0, K_CMD, CMD_AND);
      issue(0, OP_AND, 6'h00);
      @(negedge clk);
      chk("t2_alu_busy", int'(bus_a.alu_busy), 0);
      @(posedge clk); #1;
      push(0, K_CMD, CMD_SUB);
      push(0, K_CMD, CMD_OR);
      issue(0, OP_SUB, 6'h00);
      issue(0, OP_OR, 6'h00);
      @(negedge clk);

      // 3: R-type MUL, 4 busy cycles, done on the 4th, inputs ignored
      push(0, K_CMD, CMD_MUL);
      push(0, K_DONE, CMD_MUL);
      issue(0, OP_RTYPE, FUNCT_MUL);
      bus_a.in_valid = 1'b1;
      bus_a.op_in    = OP_SUB;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("t3_busy_c%0d", i + 1), int'(bus_a.alu_busy), 1);
         chk($sformatf("t3_ready_c%0d", i + 1), int'(bus_a.in_ready), 0);
         chk($sformatf("t3_done_c%0d", i + 1), int'(bus_a.done), (i == 3) ? 1 : 0);
      end
      bus_a.in_valid = 1'b0;
      @(negedge clk);
      chk("t3_busy_after", int'(bus_a.alu_busy), 0);
      chk("t3_cmd_out", int'(bus_a.cmd_out), 2);

      // 4: R-type DIV flushed in busy cycle 3
      push(0, K_CMD, CMD_DIV);
      issue(0, OP_RTYPE, FUNCT_DIV);
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus_a.flush = 1'b1;
      @(negedge clk);
      chk("t4_ready_flush", int'(bus_a.in_ready), 0);
      chk("t4_done_flush", int'(bus_a.done), 0);
      @(posedge clk); #1;
      bus_a.flush = 1'b0;
      chk("t4_busy_after", int'(bus_a.alu_busy), 0);
      chk("t4_cmd_out", int'(bus_a.cmd_out), 6);
      push(0, K_CMD, CMD_ADD);
      issue(0, OP_ADD, 6'h00);
      @(negedge clk);

      // 5: illegal funct and illegal opcode leave cmd_out at ADD
      push(0, K_ILL, CMD_ADD);
      issue(0, OP_RTYPE, 6'h3F);
      push(0, K_ILL, CMD_ADD);
      issue(0, 4'd9, 6'h00);
      @(negedge clk);
      chk("t5_busy", int'(bus_a.alu_busy), 0);
      // a legal R-type SLT after the illegal ones
      push(0, K_CMD, CMD_SLT);
      issue(0, OP_RTYPE, FUNCT_SLT);
      @(negedge clk);

      // 6: MUL_LAT=1 instance
      push(1, K_CMD, CMD_MUL);
      push(1, K_DONE, CMD_MUL);
      issue(1, OP_MUL, 6'h00);
      @(negedge clk);
      chk("t6_busy_c1", int'(bus_b.alu_busy), 1);
      chk("t6_done_c1", int'(bus_b.done), 1);
      @(negedge clk);
      chk("t6_busy_c2", int'(bus_b.alu_busy), 0);
      @(posedge clk); #1;
      bus_b.flush    = 1'b1;
      bus_b.in_valid = 1'b1;
      bus_b.op_in    = OP_AND;
      #1;
      chk("t6_ready_flush", int'(bus_b.in_ready), 0);
      @(posedge clk); #1;
      bus_b.flush    = 1'b0;
      bus_b.in_valid = 1'b0;
      @(negedge clk);
      chk("t6_cmd_out_kept", int'(bus_b.cmd_out), 2);
      chk("t6_cmd_valid", int'(bus_b.cmd_valid), 0);

      repeat (3) @(negedge clk);
      chk("q_a_empty", q_a.size(), 0);
      chk("q_b_empty", q_b.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
